// File: rtl/flash_ctrl_pkg.sv
// flash_ctrl_pkg: op codes and FSM state encoding shared by the flash sequencer.
package flash_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_RD32  = 2'b00,
    OP_WR16  = 2'b01,
    OP_ERASE = 2'b10,
    OP_RSV   = 2'b11
  } flash_op_e;

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_IDLE   = 4'd1,
    ST_RD_LO  = 4'd2,
    ST_REL_LO = 4'd3,
    ST_RD_HI  = 4'd4,
    ST_REL_HI = 4'd5,
    ST_CMD    = 4'd6,
    ST_BSY    = 4'd7,
    ST_WT     = 4'd8,
    ST_DONE   = 4'd9
  } flash_state_e;

endpackage

// File: rtl/flash_ctrl_if.sv
// flash_ctrl_if: both requester ports plus the 16-bit driver pins.
// slave = controller view, master = requesters/driver view.
interface flash_ctrl_if #(
  parameter int ADDR_W = 22
);
  logic              p0_req;
  logic [ADDR_W-1:0] p0_addr;
  logic [31:0]       p0_rdata;
  logic              p0_done;

  logic              p1_req;
  logic [1:0]        p1_op;
  logic [ADDR_W-1:0] p1_addr;
  logic [15:0]       p1_wdata;
  logic [31:0]       p1_rdata;
  logic              p1_done;

  logic [ADDR_W-1:0] drv_addr;
  logic [15:0]       drv_wdata;
  logic [15:0]       drv_rdata;
  logic              drv_read_en;
  logic              drv_write_en;
  logic              drv_erase_en;
  logic              drv_ack;

  modport slave (
    input  p0_req, p0_addr, p1_req, p1_op, p1_addr, p1_wdata, drv_rdata, drv_ack,
    output p0_rdata, p0_done, p1_rdata, p1_done,
           drv_addr, drv_wdata, drv_read_en, drv_write_en, drv_erase_en
  );

  modport master (
    output p0_req, p0_addr, p1_req, p1_op, p1_addr, p1_wdata, drv_rdata, drv_ack,
    input  p0_rdata, p0_done, p1_rdata, p1_done,
           drv_addr, drv_wdata, drv_read_en, drv_write_en, drv_erase_en
  );
endinterface

// File: rtl/flash_ctrl_arb.sv
// flash_ctrl_arb: 2-way request arbiter.
// FLASH_ARB_RR_EN defined: round robin, last-grant pointer resets to port 1.
// Otherwise fixed priority with port 1 ahead of port 0.
module flash_ctrl_arb (
`ifdef FLASH_ARB_RR_EN
  input  logic       clk,
  input  logic       rst_n,
  input  logic       take,
`endif
  input  logic [1:0] req,
  output logic       grant_valid,
  output logic [1:0] grant_onehot
);

  assign grant_valid = |req;

`ifdef FLASH_ARB_RR_EN
  logic last;

  // Remember who was granted last; that port loses the next tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last <= 1'b1;
    else if (take) last <= grant_onehot[1];
  end

  // Tie goes to the port not granted last
  always_comb begin
    grant_onehot = req;
    if (req == 2'b11) grant_onehot = last ? 2'b01 : 2'b10;
  end
`else
  // Port 1 always wins a tie
  always_comb begin
    grant_onehot = req;
    if (req[1]) grant_onehot = 2'b10;
  end
`endif

endmodule

// File: rtl/flash_ctrl.sv
// flash_ctrl: sequencer/arbiter in front of a 16-bit flash driver.
// Splits 32-bit reads into two timed halfword reads; pulses program/erase
// enables and follows the driver ack handshake.
// Build option FLASH_ARB_RR_EN: round-robin arbitration instead of p1 priority.
module flash_ctrl
  import flash_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 22,
  parameter int READ_WAIT = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  flash_ctrl_if.slave bus,
  output logic        busy
);

  localparam int               CNT_W    = $clog2(READ_WAIT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_WAIT - 1);

  flash_state_e      state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  flash_op_e         op_q, sel_op;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic              port_q;
  logic [31:0]       rbuf, p0_rdata_q, p1_rdata_q, done_data;
  logic [1:0]        req, gnt;
  logic              gnt_valid, take, enter_done, done_port, rd_hi;

  assign req  = {bus.p1_req, bus.p0_req};
  assign take = (state == ST_IDLE) && gnt_valid;

  flash_ctrl_arb u_arb (
`ifdef FLASH_ARB_RR_EN
    .clk          (clk),
    .rst_n        (rst_n),
    .take         (take),
`endif
    .req          (req),
    .grant_valid  (gnt_valid),
    .grant_onehot (gnt)
  );

  // Port 0 can only fetch
  assign sel_op = gnt[0] ? OP_RD32 : flash_op_e'(bus.p1_op);

  // State and read-wait counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next state; read phases run READ_WAIT cycles, everything else waits on ack
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      ST_INIT:   if (bus.drv_ack) state_d = ST_IDLE;
      ST_IDLE: begin
        if (take) begin
          case (sel_op)
            OP_RD32:           begin state_d = ST_RD_LO; cnt_d = CNT_LOAD; end
            OP_WR16, OP_ERASE: state_d = ST_CMD;
            default:           state_d = ST_DONE;
          endcase
        end
      end
      ST_RD_LO, ST_RD_HI: begin
        if (cnt == '0) state_d = (state == ST_RD_LO) ? ST_REL_LO : ST_REL_HI;
        else           cnt_d = cnt - 1'b1;
      end
      ST_REL_LO: if (bus.drv_ack) begin state_d = ST_RD_HI; cnt_d = CNT_LOAD; end
      ST_REL_HI: if (bus.drv_ack) state_d = ST_DONE;
      ST_CMD:    state_d = ST_BSY;
      ST_BSY:    if (!bus.drv_ack) state_d = ST_WT;
      ST_WT:     if (bus.drv_ack) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_INIT;
    endcase
  end

  // A reserved op reaches DONE straight from IDLE, before port_q/rbuf settle
  assign enter_done = (state_d == ST_DONE) && (state != ST_DONE);
  assign done_port  = (state == ST_IDLE) ? gnt[1] : port_q;
  assign done_data  = (state == ST_IDLE) ? '0 : rbuf;

  // Latch the granted request, collect halfwords, publish per-port read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_RD32;
      addr_q     <= '0;
      wdata_q    <= '0;
      port_q     <= 1'b0;
      rbuf       <= '0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      if (take) begin
        port_q  <= gnt[1];
        op_q    <= sel_op;
        addr_q  <= gnt[0] ? bus.p0_addr : bus.p1_addr;
        wdata_q <= gnt[0] ? 16'h0 : bus.p1_wdata;
        rbuf    <= '0;
      end
      if (state == ST_RD_LO && cnt == '0) rbuf[15:0]  <= bus.drv_rdata;
      if (state == ST_RD_HI && cnt == '0) rbuf[31:16] <= bus.drv_rdata;
      if (enter_done) begin
        if (done_port) p1_rdata_q <= done_data;
        else           p0_rdata_q <= done_data;
      end
    end
  end

  // Enables decode from state so an async reset drops them at once
  assign rd_hi            = (state == ST_RD_HI) || (state == ST_REL_HI);
  assign bus.drv_read_en  = (state == ST_RD_LO) || (state == ST_RD_HI);
  assign bus.drv_write_en = (state == ST_CMD) && (op_q == OP_WR16);
  assign bus.drv_erase_en = (state == ST_CMD) && (op_q == OP_ERASE);
  assign bus.drv_addr     = (op_q == OP_RD32) ? {addr_q[ADDR_W-1:1], rd_hi} : addr_q;
  assign bus.drv_wdata    = wdata_q;
  assign bus.p0_done      = (state == ST_DONE) && !port_q;
  assign bus.p1_done      = (state == ST_DONE) && port_q;
  assign bus.p0_rdata     = p0_rdata_q;
  assign bus.p1_rdata     = p1_rdata_q;
  assign busy             = (state != ST_IDLE);

endmodule

// File: tb/tb_flash_ctrl.sv
// tb_flash_ctrl: directed + randomized bench for flash_ctrl with a driver
// model (pin level) and a transaction-level reference memory.
module tb_flash_ctrl;
  import flash_ctrl_pkg::*;

  localparam int ADDR_W    = 22;
  localparam int READ_WAIT = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  flash_ctrl_if #(.ADDR_W(ADDR_W)) fif ();

  flash_ctrl #(.ADDR_W(ADDR_W), .READ_WAIT(READ_WAIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fif),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver-side memory (written by DUT pins) and reference memory (by transactions)
  logic [15:0] drv_mem [int];
  logic [15:0] ref_mem [int];

  function automatic logic [15:0] init_val(input int a);
    return 16'((a * 40503) ^ 16'h5A5A);
  endfunction

  function automatic logic [15:0] drv_rd(input int a);
    return drv_mem.exists(a) ? drv_mem[a] : init_val(a);
  endfunction

  function automatic logic [15:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic erase_blk(input bit on_drv, input int a);
    int base = a & ~255;
    for (int i = 0; i < 256; i++) begin
      if (on_drv) drv_mem[base + i] = 16'hFFFF;
      else        ref_mem[base + i] = 16'hFFFF;
    end
  endtask

  // bench state
  int          cyc = 0, t0 = 0;
  int          rd_run = 0, ack_cnt = 0, busy_len = 2;
  int          n_wr = 0, n_er = 0, n_rd = 0;
  int          done0 = 0, done1 = 0, first_port = -1, first_lat = 0;
  int          last_wr_addr = 0, last_gnt = 1;
  logic [15:0] last_wr_data = '0;
  logic [31:0] d0 = '0, d1 = '0;
  logic        ack_prev = 1'b0, p1_rise = 1'b0;
  int          rel_log [$];

  // one clock: sample at negedge, run the driver model, retire dones
  task automatic step();
    logic ack_edge;
    int   rel;
    @(negedge clk);
    cyc++;
    ack_edge = fif.drv_ack;
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) fif.drv_ack = 1'b1;
    end
    if (fif.drv_read_en) rd_run++;
    else if (rd_run != 0) begin
      chk("read_en_len", rd_run, READ_WAIT);
      rd_run = 0;
      n_rd++;
      rel = $urandom_range(0, 3);
      rel_log.push_back(rel);
      if (rel != 0) begin fif.drv_ack = 1'b0; ack_cnt = rel; end
    end
    if (fif.drv_write_en) begin
      n_wr++;
      last_wr_addr = int'(fif.drv_addr);
      last_wr_data = fif.drv_wdata;
      drv_mem[int'(fif.drv_addr)] = fif.drv_wdata;
      fif.drv_ack = 1'b0;
      ack_cnt = busy_len;
    end
    if (fif.drv_erase_en) begin
      n_er++;
      erase_blk(1'b1, int'(fif.drv_addr));
      fif.drv_ack = 1'b0;
      ack_cnt = busy_len;
    end
    if (fif.p0_done) begin
      done0++;
      d0 = fif.p0_rdata;
      fif.p0_req = 1'b0;
      if (first_port < 0) begin first_port = 0; first_lat = cyc - t0; end
    end
    if (fif.p1_done) begin
      done1++;
      d1 = fif.p1_rdata;
      p1_rise = ack_edge && !ack_prev;
      fif.p1_req = 1'b0;
      if (first_port < 0) begin first_port = 1; first_lat = cyc - t0; end
    end
    fif.drv_rdata = drv_rd(int'(fif.drv_addr));
    ack_prev = ack_edge;
  endtask

  // issue one or two requests from idle, check against the reference model
  task automatic run_round(input bit use0, input bit use1, input logic [1:0] op,
                           input int a0, input int a1, input logic [15:0] wd, input int blen);
    int          exp_first, guard, wr0, er0, rd0, nreads;
    logic [31:0] e0, e1;
    e0 = '0; e1 = '0; nreads = 0;
    wr0 = n_wr; er0 = n_er; rd0 = n_rd;
    if (use0 && use1) begin
`ifdef FLASH_ARB_RR_EN
      exp_first = (last_gnt == 1) ? 0 : 1;
`else
      exp_first = 1;
`endif
    end else exp_first = use1 ? 1 : 0;
    for (int k = 0; k < 2; k++) begin
      int p = (k == 0) ? exp_first : 1 - exp_first;
      if (p == 0 && use0) begin
        e0 = {ref_rd(a0 | 1), ref_rd(a0 & ~1)};
        nreads++;
        last_gnt = 0;
      end
      if (p == 1 && use1) begin
        case (op)
          2'b00:   begin e1 = {ref_rd(a1 | 1), ref_rd(a1 & ~1)}; nreads++; end
          2'b01:   ref_mem[a1] = wd;
          2'b10:   erase_blk(1'b0, a1);
          default: e1 = '0;
        endcase
        last_gnt = 1;
      end
    end
    busy_len = blen;
    fif.p0_addr = ADDR_W'(a0);
    fif.p1_addr = ADDR_W'(a1);
    fif.p1_op = op;
    fif.p1_wdata = wd;
    fif.p0_req = use0;
    fif.p1_req = use1;
    t0 = cyc; first_port = -1; done0 = 0; done1 = 0; p1_rise = 1'b0;
    rel_log.delete();
    guard = 0;
    while ((done0 + done1) < (int'(use0) + int'(use1)) && guard < 2000) begin
      step();
      guard++;
    end
    chk("round_timeout", guard < 2000, 1);
    repeat (3) step();
    chk("idle_after", busy, 0);
    chk("p0_done_cnt", done0, int'(use0));
    chk("p1_done_cnt", done1, int'(use1));
    if (use0 && use1) chk("tie_winner", first_port, exp_first);
    if (use0) begin
      chk("p0_rdata", d0, e0);
      chk("p0_rdata_hold", fif.p0_rdata, e0);
    end
    if (use1 && (op == 2'b00 || op == 2'b11)) chk("p1_rdata", d1, e1);
    chk("rd_phases", n_rd - rd0, 2 * nreads);
    chk("wr_pulses", n_wr - wr0, (use1 && op == 2'b01) ? 1 : 0);
    chk("er_pulses", n_er - er0, (use1 && op == 2'b10) ? 1 : 0);
    if (use1 && op == 2'b01) begin
      chk("wr_addr", last_wr_addr, a1);
      chk("wr_data", last_wr_data, wd);
    end
    if (use1 && (op == 2'b01 || op == 2'b10)) chk("done_after_ack", p1_rise, 1);
    if ((exp_first == 0 || op == 2'b00) && rel_log.size() >= 2)
      chk("rd_latency", first_lat, 2 * (READ_WAIT + 1) + 1 + rel_log[0] + rel_log[1]);
  endtask

  initial begin
    fif.p0_req = 0; fif.p0_addr = '0; fif.p1_req = 0; fif.p1_op = '0;
    fif.p1_addr = '0; fif.p1_wdata = '0; fif.drv_rdata = '0; fif.drv_ack = 1'bx;

    // 1: reset state, then INIT waits for the driver ack
    repeat (2) step();
    chk("rst_busy", busy, 1);
    chk("rst_enables", {fif.drv_read_en, fif.drv_write_en, fif.drv_erase_en}, 0);
    chk("rst_dones", {fif.p0_done, fif.p1_done}, 0);
    chk("rst_drv_addr", fif.drv_addr, 0);
    chk("rst_rdata", fif.p0_rdata | fif.p1_rdata, 0);
    rst_n = 1'b1;
    repeat (3) begin step(); chk("init_wait_ack", busy, 1); end
    fif.drv_ack = 1'b1;
    step();
    chk("init_to_idle", busy, 0);
    chk("init_no_ops", n_rd + n_wr + n_er, 0);

    // 2: fetch across a halfword pair
    drv_mem[32'h100] = 16'hBEEF; ref_mem[32'h100] = 16'hBEEF;
    drv_mem[32'h101] = 16'hDEAD; ref_mem[32'h101] = 16'hDEAD;
    run_round(1, 0, OP_RD32, 32'h101, 0, 16'h0, 2);
    chk("fetch_deadbeef", d0, 32'hDEADBEEF);

    // 3: program with a long driver busy time
    run_round(0, 1, OP_WR16, 0, 32'h20, 16'h1234, 50);

    // 4: simultaneous reads, twice
    run_round(1, 1, OP_RD32, 32'h200, 32'h301, 16'h0, 2);
    run_round(1, 1, OP_RD32, 32'h20, 32'h100, 16'h0, 2);

    // 5: erase, reserved op, then read back the erased block
    run_round(0, 1, OP_ERASE, 0, 32'h1A7, 16'h0, 5);
    run_round(0, 1, OP_RSV, 0, 32'h44, 16'h0, 2);
    run_round(1, 0, OP_RD32, 32'h1A0, 0, 16'h0, 2);
    chk("erased_word", d0, 32'hFFFFFFFF);

    // randomized mix against the reference model
    for (int r = 0; r < 40; r++) begin
      int pat = $urandom_range(0, 2);
      run_round(pat != 1, pat != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 1023),
                $urandom_range(0, 1023), 16'($urandom), $urandom_range(2, 12));
    end

    // 6: reset during the high half of a read
    fif.p0_addr = ADDR_W'(32'h40);
    fif.p0_req = 1'b1;
    done0 = 0; done1 = 0;
    repeat (16) step();
    chk("rd_hi_active", fif.drv_read_en, 1);
    chk("rd_hi_addr", fif.drv_addr, 32'h41);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_read_en", fif.drv_read_en, 0);
    chk("rst_mid_busy", busy, 1);
    fif.p0_req = 1'b0; rd_run = 0; ack_cnt = 0; fif.drv_ack = 1'b0; last_gnt = 1;
    step();
    rst_n = 1'b1;
    repeat (3) begin step(); chk("rst_wait_ack", busy, 1); end
    fif.drv_ack = 1'b1;
    step();
    chk("rst_idle", busy, 0);
    chk("rst_no_done", done0 + done1, 0);
    run_round(1, 0, OP_RD32, 32'h40, 0, 16'h0, 2);
    run_round(1, 1, OP_RD32, 32'h80, 32'h90, 16'h0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
